// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM port arbiter.
//   - arb_state_t : transaction sequencer states
//   - AW_DEF/DW_DEF : default RAM word-address / data widths
//   - CNT_W : width of the read-latency wait counter (RD_LAT up to 7)
//   - onehot2 : port index -> one-hot owner vector
package ram_arb_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0]     : pending requests
//   last_winner  : index granted most recently
//   grant_valid  : at least one request pending
//   grant_idx    : chosen index (on a tie, the one that did not win last)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;

    always_comb begin
        if (&req) grant_idx = ~last_winner;
        else      grant_idx = req[1];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between two req/ack requesters.
// One transaction at a time, round-robin on ties. Every output is a register:
// the next-value logic below computes what each output holds in the next state.
//   clk, rst           : clock, asynchronous active-high reset
//   m0_* / m1_*        : requester ports (req held until ack; ack is a 1-cycle pulse,
//                        rdata valid with ack on reads)
//   ram_addr/we/din    : RAM command; ram_dout returns RD_LAT cycles after address
//   owner              : one-hot current owner, 00 when idle
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    owner
);

    arb_state_t       state, state_d;
    logic             last_winner, last_winner_d;
    logic             win, win_d;          // latched winner index
    logic             lat_we, lat_we_d;    // latched write/read flag
    logic [CNT_W-1:0] cnt, cnt_d;          // read-latency countdown

    logic [AW-1:0]    ram_addr_d;
    logic             ram_we_d;
    logic [DW-1:0]    ram_din_d;
    logic [1:0]       owner_d;
    logic             m0_ack_d, m1_ack_d;
    logic [DW-1:0]    m0_rdata_d, m1_rdata_d;

    logic             grant_valid, grant_idx;

    rr_arb2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_winner (last_winner),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_winner <= 1'b1;       // port 0 wins the first tie
            win         <= 1'b0;
            lat_we      <= 1'b0;
            cnt         <= '0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_din     <= '0;
            owner       <= 2'b00;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            state       <= state_d;
            last_winner <= last_winner_d;
            win         <= win_d;
            lat_we      <= lat_we_d;
            cnt         <= cnt_d;
            ram_addr    <= ram_addr_d;
            ram_we      <= ram_we_d;
            ram_din     <= ram_din_d;
            owner       <= owner_d;
            m0_ack      <= m0_ack_d;
            m1_ack      <= m1_ack_d;
            m0_rdata    <= m0_rdata_d;
            m1_rdata    <= m1_rdata_d;
        end
    end

    always_comb begin
        state_d       = state;
        last_winner_d = last_winner;
        win_d         = win;
        lat_we_d      = lat_we;
        cnt_d         = cnt;
        ram_addr_d    = ram_addr;   // address holds, including through IDLE
        ram_we_d      = 1'b0;       // only ever high for the ISSUE cycle
        ram_din_d     = ram_din;
        owner_d       = owner;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        m0_rdata_d    = m0_rdata;
        m1_rdata_d    = m1_rdata;

        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    // Capture the winner's command here; the registers driven
                    // below are what the RAM sees during ISSUE.
                    win_d         = grant_idx;
                    last_winner_d = grant_idx;
                    lat_we_d      = grant_idx ? m1_we : m0_we;
                    ram_addr_d    = grant_idx ? m1_addr : m0_addr;
                    owner_d       = onehot2(grant_idx);
                    if (grant_idx ? m1_we : m0_we) begin
                        ram_we_d  = 1'b1;
                        ram_din_d = grant_idx ? m1_wdata : m0_wdata;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lat_we) begin
                    if (win) m1_ack_d = 1'b1;
                    else     m0_ack_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - 1'b1;
                // cnt==1 marks the cycle ram_dout carries the addressed word
                if (cnt == CNT_W'(1)) begin
                    if (win) begin
                        m1_rdata_d = ram_dout;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = ram_dout;
                        m0_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                owner_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one RD_LAT=1 instance (main tests) and
// one RD_LAT=3 instance (latency test), each with a behavioural RAM model.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // ---- RD_LAT = 1 instance ----
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [9:0]  m0_addr, m1_addr, ram_addr;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_din, ram_dout;
    logic        m0_ack, m1_ack, ram_we;
    logic [1:0]  owner;

    ram_port_arbiter #(.AW(10), .DW(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .owner(owner)
    );

    logic [31:0] mem1 [1024];
    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_din;
        ram_dout <= mem1[ram_addr];
    end

    // ---- RD_LAT = 3 instance ----
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [9:0]  b_m0_addr, b_m1_addr, b_ram_addr;
    logic [31:0] b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_ram_din, b_ram_dout;
    logic        b_m0_ack, b_m1_ack, b_ram_we;
    logic [1:0]  b_owner;

    ram_port_arbiter #(.AW(10), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_din(b_ram_din),
        .ram_dout(b_ram_dout), .owner(b_owner)
    );

    logic [31:0] mem3 [1024];
    logic [31:0] p0, p1;
    always @(posedge clk) begin
        if (b_ram_we) mem3[b_ram_addr] <= b_ram_din;
        p0         <= mem3[b_ram_addr];
        p1         <= p0;
        b_ram_dout <= p1;
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'hA500_0000 | i;
            mem3[i] = 32'hA500_0000 | i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0;

        // ---- reset state ----
        step(); step(); step();
        chk("rst_we",     32'(ram_we),   32'h0);
        chk("rst_addr",   32'(ram_addr), 32'h0);
        chk("rst_din",    ram_din,       32'h0);
        chk("rst_owner",  32'(owner),    32'h0);
        chk("rst_ack0",   32'(m0_ack),   32'h0);
        chk("rst_ack1",   32'(m1_ack),   32'h0);
        chk("rst_rdata0", m0_rdata,      32'h0);
        chk("rst_rdata1", m1_rdata,      32'h0);
        rst = 0;
        step();

        // ---- m0 write 0x005 <= DEADBEEF ----
        m0_req = 1; m0_we = 1; m0_addr = 10'h005; m0_wdata = 32'hDEADBEEF;
        step();                                   // edge k: ISSUE
        chk("w_issue_we",    32'(ram_we),   32'h1);
        chk("w_issue_addr",  32'(ram_addr), 32'h005);
        chk("w_issue_din",   ram_din,       32'hDEADBEEF);
        chk("w_issue_owner", 32'(owner),    32'h1);
        chk("w_issue_ack",   32'(m0_ack),   32'h0);
        step();                                   // DONE
        chk("w_done_ack",    32'(m0_ack),   32'h1);
        chk("w_done_we",     32'(ram_we),   32'h0);
        chk("w_done_owner",  32'(owner),    32'h1);
        chk("w_done_ack1",   32'(m1_ack),   32'h0);
        m0_req = 0;
        step();                                   // IDLE
        chk("w_idle_ack",    32'(m0_ack),   32'h0);
        chk("w_idle_owner",  32'(owner),    32'h0);
        chk("w_idle_addr",   32'(ram_addr), 32'h005);

        // ---- m1 read 0x005, RD_LAT=1 ----
        m1_req = 1; m1_we = 0; m1_addr = 10'h005;
        step();                                   // ISSUE
        chk("r_issue_owner", 32'(owner),    32'h2);
        chk("r_issue_we",    32'(ram_we),   32'h0);
        chk("r_issue_addr",  32'(ram_addr), 32'h005);
        step();                                   // WAIT
        chk("r_wait_ack",    32'(m1_ack),   32'h0);
        step();                                   // DONE (k+3)
        chk("r_done_ack1",   32'(m1_ack),   32'h1);
        chk("r_done_rdata",  m1_rdata,      32'hDEADBEEF);
        chk("r_done_ack0",   32'(m0_ack),   32'h0);
        chk("r_done_rdata0", m0_rdata,      32'h0);
        m1_req = 0;
        step();
        chk("r_idle_ack1",   32'(m1_ack),   32'h0);

        // ---- contention: both held, continuous writes ----
        rst = 1; step(); rst = 0; step();
        m0_req = 1; m0_we = 1; m0_addr = 10'h010; m0_wdata = 32'h1111_1111;
        m1_req = 1; m1_we = 1; m1_addr = 10'h020; m1_wdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            step();                               // ISSUE
            chk($sformatf("rr%0d_owner", i), 32'(owner), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr%0d_addr", i), 32'(ram_addr), (i % 2 == 0) ? 32'h010 : 32'h020);
            step();                               // DONE
            chk($sformatf("rr%0d_ack0", i), 32'(m0_ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr%0d_ack1", i), 32'(m1_ack), (i % 2 == 0) ? 32'h0 : 32'h1);
            step();                               // IDLE
            chk($sformatf("rr%0d_idle", i), 32'(owner), 32'h0);
        end
        m0_req = 0; m1_req = 0;
        step();
        chk("rr_quiet_owner", 32'(owner), 32'h0);

        // ---- reset during WAIT of an m0 read ----
        m0_req = 1; m0_we = 0; m0_addr = 10'h010;
        step();                                   // ISSUE
        step();                                   // WAIT
        rst = 1; m0_req = 0;
        #1;
        chk("mrst_we",    32'(ram_we), 32'h0);
        chk("mrst_owner", 32'(owner),  32'h0);
        chk("mrst_ack",   32'(m0_ack), 32'h0);
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mrst_noack%0d", i), 32'(m0_ack), 32'h0);
        end
        m0_req = 1; m0_we = 0; m0_addr = 10'h010;
        step(); step(); step();                   // ISSUE, WAIT, DONE
        chk("post_ack",   32'(m0_ack), 32'h1);
        chk("post_rdata", m0_rdata,    32'h1111_1111);
        m0_req = 0;
        step();

        // ---- requester changes after grant ----
        m0_req = 1; m0_we = 0; m0_addr = 10'h020;
        step();                                   // ISSUE
        chk("lat_issue_addr", 32'(ram_addr), 32'h020);
        m0_req = 0;
        step();                                   // WAIT
        m0_addr = 10'h3FF;
        chk("lat_wait_addr", 32'(ram_addr), 32'h020);
        step();                                   // DONE
        chk("lat_ack",    32'(m0_ack), 32'h1);
        chk("lat_rdata",  m0_rdata,    32'h2222_2222);
        chk("lat_rdata1", m1_rdata,    32'h0);
        step();
        chk("lat_ack_once", 32'(m0_ack), 32'h0);
        step();
        chk("lat_no_regrant", 32'(owner), 32'h0);

        // ---- RD_LAT=3 instance: m1 read 0x007 ----
        b_m1_req = 1; b_m1_we = 0; b_m1_addr = 10'h007;
        step();                                   // ISSUE
        chk("l3_issue_addr",  32'(b_ram_addr), 32'h007);
        chk("l3_issue_owner", 32'(b_owner),    32'h2);
        b_m1_addr = 10'h100;
        for (int i = 0; i < 3; i++) begin
            step();                               // WAIT x3
            chk($sformatf("l3_wait%0d_addr", i), 32'(b_ram_addr), 32'h007);
            chk($sformatf("l3_wait%0d_ack", i),  32'(b_m1_ack),   32'h0);
        end
        step();                                   // DONE (k+5)
        chk("l3_ack",   32'(b_m1_ack),  32'h1);
        chk("l3_rdata", b_m1_rdata,     32'hA500_0007);
        chk("l3_ack0",  32'(b_m0_ack),  32'h0);
        chk("l3_rdata0", b_m0_rdata,    32'h0);
        b_m1_req = 0;
        step();
        chk("l3_idle_ack", 32'(b_m1_ack), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 1K x 32 data block RAM between two requesters, each with a req/ack handshake.
  - Port 0: CPU side, fed by MIO_BUS RAM decode.
  - Port 1: secondary master, e.g. the life-game pattern loader/DMA.
- Grants are round-robin, one transaction at a time.
- Sequences RAM address, write enable and write data, waits the RAM read latency, then returns registered read data.
- Sits between MIO_BUS/DMA and RAM_B and replaces the direct ram_addr/data_ram_we wiring.

Parameters:
- AW, 10, RAM word-address width.
- DW, 32, data width.
- RD_LAT, 1, cycles from address presented to valid ram_dout (range 1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- m0_req  in  1  port 0 request; held until m0_ack
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 word address
- m0_wdata  in  DW  port 0 write data
- m0_ack  out  1  port 0 one-cycle completion pulse
- m0_rdata  out  DW  port 0 read data, valid when m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data
- owner  out  2  bit i = port i owns the RAM (one-hot, 00 when idle)

Behaviour:
- All outputs are registered.
- Reset (async, immediate, also mid-transaction):
  - state IDLE, last_winner=1 (so port 0 wins first tie).
  - ram_we=0, ram_addr=0, ram_din=0, m*_ack=0, m*_rdata=0, owner=00.
  - Any in-flight transaction is abandoned and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: that port wins.
  - Both req: winner = port != last_winner.
  - On a win, latch winner, we, addr and wdata into internal registers; go to ISSUE; last_winner <= winner.
- ISSUE (1 cycle):
  - ram_addr=latched addr, owner=one-hot winner.
  - If write: ram_we=1, ram_din=wdata, next DONE.
  - If read: ram_we=0, wait counter loaded with RD_LAT, next WAIT.
- WAIT:
  - ram_addr held, counter decrements.
  - When counter reaches 1, capture ram_dout into the winner's m*_rdata; next DONE.
- DONE (1 cycle):
  - Winner's m*_ack=1, ram_we=0; next IDLE.
  - The other port's ack stays 0 and its rdata is unchanged.
- Latency, with req first sampled high at edge k:
  - Write: ram_we high in cycle k+1, ack in cycle k+2.
  - Read: ack in cycle k+2+RD_LAT.
- Throughput: at most one transaction every 3 cycles (write) or 3+RD_LAT cycles (read). IDLE always costs one cycle, so the losing requester is served next and there is no starvation.
- Requester rules:
  - Signals are latched at grant, so later changes are ignored.
  - If req is dropped before ack, the RAM access still completes and ack still pulses.
  - A req still high in the cycle after ack is treated as a new request.
- The non-winner's req is ignored during ISSUE, WAIT and DONE and remains pending.
- Simultaneous req on the cycle of another port's DONE is arbitrated in the following IDLE cycle by last_winner.
- ram_addr keeps its last value in IDLE; ram_we is never high outside ISSUE.

Decomposition:
- Package ram_arb_pkg:
  - State encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
  - AW/DW defaults and RD_LAT counter width (3).
- Sub-module rr_arb2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_winner.
  - Outputs: grant_valid, grant_idx.
  - Reused later for the VGA/CPU cell-RAM arbiter.

Test Plan:
- Reset, then m0 write addr 0x005 data 0xDEADBEEF → ram_we=1 with ram_addr=0x005 and ram_din=0xDEADBEEF one cycle after sample; m0_ack one cycle later; owner=01 during ISSUE/DONE.
- m1 read addr 0x005, RD_LAT=1, RAM model returns the stored word → m1_ack at k+3 with m1_rdata=0xDEADBEEF; m0_ack stays 0.
- m0 and m1 req asserted together, both held, continuous writes → grants alternate 0,1,0,1; first grant goes to port 0 after reset; no port gets two consecutive grants while the other is pending.
- rst pulsed during WAIT of an m0 read → ram_we=0, owner=00 and m0_ack=0 immediately; no ack after release; next req is served normally.
- m0 drops req in ISSUE, and m0_addr changes in WAIT → RAM access uses the latched address; m0_ack still pulses once.
- RD_LAT=3 build, m1 read → ack at k+5; ram_addr stable through ISSUE and all WAIT cycles.
